// File: rtl/mem_access_unit_if.sv
// Request, response and data-memory signals of the memory access unit.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
) ();
  // Requester side
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  // Response to the load extender
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_signed;
  logic [1:0]        rsp_size;
  logic              rsp_err;
  // Data memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  // The unit itself
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, rsp_valid, rsp_data, rsp_signed, rsp_size, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // Environment: requester plus data memory
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, rsp_valid, rsp_data, rsp_signed, rsp_size, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: alignment check, lane steering, req/ack memory handshake with timeout.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned    CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e state_q, state_d;

  // Latched request
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CntW-1:0]   cnt_q;

  // Response registers, held between pulses
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_signed_q;
  logic [1:0]        rsp_size_q;
  logic              rsp_err_q;

  logic              accept, misaligned, timeout;
  logic [3:0]        be;
  logic [DATA_W-1:0] lane_wdata, rd_shift, load_data;

  assign accept  = (state_q == StIdle) && bus.req_valid;
  assign timeout = (cnt_q == CntMax);

  // Alignment check on the incoming request
  always_comb begin
    unique case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Byte enables, replicated store data and right-aligned load data from the latched request
  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata_q;
    rd_shift   = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    load_data  = rd_shift;
    unique case (size_q)
      2'b00: begin
        be         = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
        load_data  = {24'h0, rd_shift[7:0]};
      end
      2'b01: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
        load_data  = {16'h0, rd_shift[15:0]};
      end
      default: be = 4'b1111;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; ack wins over a simultaneous timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.req_valid) state_d = misaligned ? StResp : StBusy;
      StBusy: if (bus.mem_ack || timeout) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; memory bus is zero outside BUSY
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = 4'b0000;
    bus.mem_wdata = '0;
    if (state_q == StBusy) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      bus.mem_be    = be;
      bus.mem_wdata = lane_wdata;
    end
  end

  // Request latch, wait counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_signed_q <= 1'b0;
      rsp_size_q   <= 2'b00;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        cnt_q    <= '0;
        if (misaligned) begin
          rsp_data_q   <= '0;
          rsp_signed_q <= bus.req_signed;
          rsp_size_q   <= bus.req_size;
          rsp_err_q    <= 1'b1;
        end
      end
      if (state_q == StBusy) begin
        if (bus.mem_ack) begin
          rsp_data_q   <= we_q ? '0 : load_data;
          rsp_signed_q <= signed_q;
          rsp_size_q   <= size_q;
          rsp_err_q    <= 1'b0;
        end else if (timeout) begin
          rsp_data_q   <= '0;
          rsp_signed_q <= signed_q;
          rsp_size_q   <= size_q;
          rsp_err_q    <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_signed = rsp_signed_q;
  assign bus.rsp_size   = rsp_size_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the execute stage and the data memory. It is directly upstream of the load sign-extension stage.
- Takes one load or store request at a time and checks alignment.
- Generates byte-lane enables and shifted store data, then runs a req/ack handshake with the data memory.
- For loads, returns the addressed byte, halfword or word right-aligned with the upper bits zeroed, plus a signed flag. The downstream extender uses these to finish the load value.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, memory word width; fixed at 32, other values unsupported
TIMEOUT, 15, max cycles waiting for mem_ack before aborting with error

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  load is signed (LB/LH); ignored for stores and words
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle pulse: request complete
rsp_data  out  32  load data, right-aligned, upper bits zero; 0 for stores and errors
rsp_signed  out  1  registered req_signed, for the downstream extender
rsp_size  out  2  registered req_size
rsp_err  out  1  valid with rsp_valid: misaligned, illegal size or timeout
mem_req  out  1  memory request, held until ack
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-shifted store data
mem_rdata  in  32  read word, valid when mem_ack high
mem_ack  in  1  memory completes request this cycle

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready=1.
  - Timeout counter clears.
- States are IDLE, BUSY and RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch we, size, signed, addr and wdata.
- Alignment check on acceptance:
  - Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Misaligned: go directly to RESP with err=1. No mem_req is ever asserted.
  - Aligned: go to BUSY. mem_req rises in the cycle after acceptance.
- mem_be:
  - byte: 1<<addr[1:0]
  - half: 0011 or 1100, selected by addr[1]
  - word: 1111
- Store data:
  - byte: wdata[7:0] replicated ×4
  - half: wdata[15:0] replicated ×2
  - word: unchanged
- Loads drive mem_be with the same pattern; memory may ignore it.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_ack.
  - Counter increments each cycle mem_ack=0.
  - On mem_ack=1:
    - Deassert mem_req next cycle.
    - For loads, capture mem_rdata >> (8*addr[1:0]), masked to the size: byte [7:0], half [15:0], word full.
    - Go to RESP.
  - If the counter reaches TIMEOUT with no ack: drop mem_req, go to RESP with err=1 and rsp_data=0.
  - mem_ack arriving in the same cycle the counter hits TIMEOUT counts as success.
- RESP:
  - rsp_valid=1 for exactly one cycle, together with rsp_data, rsp_signed, rsp_size and rsp_err.
  - Then go to IDLE.
  - req_ready=0 during RESP, so there are no back-to-back accepts.
  - rsp_data, rsp_signed, rsp_size and rsp_err hold their values after the pulse until the next RESP.
- Latency:
  - Aligned request with ack on the first mem_req cycle: accept at T, mem_req at T+1, ack at T+1, rsp_valid at T+2.
  - Misaligned: rsp_valid at T+1.
- Stray inputs:
  - mem_ack outside BUSY is ignored.
  - req_valid outside IDLE is ignored; the requester holds it.
- Reset mid-operation: mem_req drops immediately (async), the transaction is lost and no rsp_valid is produced.

Test Plan:
- LB at addr 0x1003, mem_rdata=0xAB000000, ack on first mem_req cycle -> mem_addr=0x1000, mem_be=1000, rsp_valid 2 cycles after accept with rsp_data=0x000000AB, rsp_signed=1, rsp_err=0.
- SH at addr 0x22, wdata=0x1234BEEF -> mem_be=1100, mem_wdata=0xBEEFBEEF, mem_we=1, rsp_data=0, rsp_err=0.
- LW at 0x41 -> no mem_req ever asserted, rsp_valid one cycle after accept, rsp_err=1.
- LH at 0x8 with mem_ack delayed 5 cycles -> mem_req stable for 6 cycles with unchanged addr/be, rsp_data=mem_rdata[15:0].
- LW with mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 waiting cycles, rsp_err=1, rsp_data=0; next request is accepted normally.
- rst_n pulsed low during BUSY -> mem_req=0 and req_ready=1 immediately, no rsp_valid; subsequent SB completes correctly.
